// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - front-end stall/flush sequencing for a 5-stage MIPS pipeline
// Resolves load-use, taken-branch, mult/div occupancy and fetch-wait into pipeline register controls.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_branch_taken,
    input  logic             EX_md_start,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_hold,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // The start cycle counts toward occupancy, and md_cnt==0 is itself a wait cycle.
    localparam logic [7:0]       MD_RELOAD = 8'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c, ex_hold_c, md_busy_c;

    assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                      ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_hold_c     = 1'b0;
        md_busy_c     = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (EX_branch_taken) begin
                        pc_en_c       = 1'b1;
                        if_id_en_c    = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (EX_md_start) begin
                        ex_hold_c = 1'b1;
                        md_busy_c = 1'b1;
                        stall_inc = 1'b1;
                        md_cnt_d  = MD_RELOAD;
                        state_d   = MD_WAIT;
                    end else if (load_use) begin
                        id_ex_flush_c = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (!imem_ready) begin
                        if_id_en_c    = 1'b1;
                        if_id_flush_c = 1'b1;
                        stall_inc     = 1'b1;
                    end else begin
                        pc_en_c    = 1'b1;
                        if_id_en_c = 1'b1;
                    end
                end
                MD_WAIT: begin
                    ex_hold_c = 1'b1;
                    md_busy_c = 1'b1;
                    stall_inc = 1'b1;
                    if (md_cnt_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            md_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en       = pc_en_c;
    assign if_id_en    = if_id_en_c;
    assign if_id_flush = if_id_flush_c;
    assign id_ex_flush = id_ex_flush_c;
    assign ex_hold     = ex_hold_c;
    assign md_busy     = md_busy_c;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int unsigned MD_LATENCY = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int          CNT_SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ID_rs, ID_rt, EX_rt;
    logic             ID_uses_rt, EX_MemRead, EX_branch_taken, EX_md_start, imem_ready;
    logic             pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, md_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_stall_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .EX_branch_taken(EX_branch_taken), .EX_md_start(EX_md_start),
        .imem_ready(imem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ctrl;       // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, md_busy}
        int         stall;
        int         flush;
        bit         cnt_known;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference model: remaining wait cycles and unbounded event totals.
    int  md_left = 0;
    int  stall_tot = 0;
    int  flush_tot = 0;
    bit  known = 1'b0;

    function automatic int sat(input int v);
        return (v > CNT_SAT) ? CNT_SAT : v;
    endfunction

    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic br, input logic md,
                       input logic im);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst = r; ID_rs = rs; ID_rt = rt; ID_uses_rt = urt; EX_MemRead = mr; EX_rt = ert;
        EX_branch_taken = br; EX_md_start = md; imem_ready = im;

        e.stall = sat(stall_tot);
        e.flush = sat(flush_tot);
        e.cnt_known = known;
        e.cyc = cyc_no;
        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));

        if (r) begin
            e.ctrl = 6'b000000;
            md_left = 0; stall_tot = 0; flush_tot = 0; known = 1'b1;
        end else if (md_left > 0) begin
            e.ctrl = 6'b000011;
            md_left--; stall_tot++;
        end else if (br) begin
            e.ctrl = 6'b111100;
            flush_tot++;
        end else if (md) begin
            e.ctrl = 6'b000011;
            md_left = MD_LATENCY - 1; stall_tot++;
        end else if (lu) begin
            e.ctrl = 6'b000100;
            stall_tot++;
        end else if (!im) begin
            e.ctrl = 6'b011000;
            stall_tot++;
        end else begin
            e.ctrl = 6'b110000;
        end
        exp_q.push_back(e);
        cyc_no++;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, md_busy};
                n_cmp++;
                if (got !== e.ctrl) begin
                    n_bad++;
                    $display("FAIL ctrl cyc=%0d got=%b want=%b", e.cyc, got, e.ctrl);
                end
                if (e.cnt_known) begin
                    n_cmp++;
                    if (stall_cnt !== CNT_W'(e.stall)) begin
                        n_bad++;
                        $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.stall);
                    end
                    n_cmp++;
                    if (flush_cnt !== CNT_W'(e.flush)) begin
                        n_bad++;
                        $display("FAIL flush_cnt cyc=%0d got=%0d want=%0d", e.cyc, flush_cnt, e.flush);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; ID_rs = '0; ID_rt = '0; ID_uses_rt = 1'b0; EX_MemRead = 1'b0; EX_rt = '0;
        EX_branch_taken = 1'b0; EX_md_start = 1'b0; imem_ready = 1'b1;

        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        // load-use on rs, then the same pattern against $zero
        cyc(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        // load-use via rt only matters when rt is a source
        cyc(1'b0, 5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        // branch wins over md_start, load-use and fetch wait
        cyc(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        idle();
        // mult/div occupancy, inputs ignored while waiting
        cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        idle(); idle(); idle(); idle();
        // reset aborts MD_WAIT
        cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(); idle();
        cyc(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        idle(); idle();
        // fetch wait
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        // saturation
        for (int i = 0; i < 20; i++) cyc(1'b0, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 5'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
